// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared enums and width helper for the multiply/divide unit
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } MulDivCodeEnum;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } MulDivStateEnum;

    // Number of bits needed to hold the value itself (so a counter can reach it)
    function automatic int GetMinWidth(input int value);
        int w;
        w = 1;
        while ((1 << w) <= value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// rtl/mul_div_step.sv - one radix-2 iteration of shift-add multiply or restoring divide
module mul_div_step #(
    parameter int BitWidth = 32
) (
    input  logic                    div_mode,
    input  logic [2*BitWidth-1:0]   acc,
    input  logic [BitWidth-1:0]     operand,
    output logic [2*BitWidth-1:0]   acc_next,
    output logic                    q_bit
);

    logic [BitWidth:0]   sum;
    logic [BitWidth:0]   trial;
    logic [BitWidth:0]   diff;

    // Multiply: {hi, multiplier} accumulator, add on lsb then shift right.
    // Divide: {remainder, dividend} accumulator, shift left then trial-subtract.
    // The remainder stays below the divisor, so trial < 2*divisor and the msb of a
    // (BitWidth+1)-bit difference is a clean borrow flag.
    always_comb begin
        sum      = {1'b0, acc[2*BitWidth-1:BitWidth]}
                 + {1'b0, (acc[0] ? operand : {BitWidth{1'b0}})};
        trial    = {acc[2*BitWidth-1:BitWidth], acc[BitWidth-1]};
        diff     = trial - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = {sum, acc[BitWidth-1:1]};
        if (div_mode) begin
            q_bit    = ~diff[BitWidth];
            acc_next = {(q_bit ? diff[BitWidth-1:0] : trial[BitWidth-1:0]),
                        acc[BitWidth-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int BitWidth = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  MulDivCodeEnum       op,
    input  logic [BitWidth-1:0] a,
    input  logic [BitWidth-1:0] b,
    input  logic                cancel,
    output logic                busy,
    output logic                done,
    output logic [BitWidth-1:0] hi,
    output logic [BitWidth-1:0] lo,
    output logic                divByZero
);

    localparam int CntW = GetMinWidth(BitWidth);
    localparam logic [CntW-1:0] LastStep = CntW'(BitWidth - 1);

    MulDivStateEnum          state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [2*BitWidth-1:0]   acc_q, acc_d;
    logic [BitWidth-1:0]     opnd_q, opnd_d;
    logic                    is_div_q, is_div_d;
    logic                    neg_main_q, neg_main_d;
    logic                    neg_rem_q, neg_rem_d;
    logic [BitWidth-1:0]     hi_q, hi_d;
    logic [BitWidth-1:0]     lo_q, lo_d;
    logic                    dbz_q, dbz_d;
    logic                    done_q, done_d;
    logic                    pend_q, pend_d;

    logic                    is_signed_op, is_div_op, is_long_op, b_zero;
    logic                    a_neg, b_neg;
    logic [BitWidth-1:0]     a_mag, b_mag;
    logic [2*BitWidth-1:0]   step_acc;
    logic                    step_q;
    logic [2*BitWidth-1:0]   prod_fixed;
    logic [BitWidth-1:0]     quot_fixed, rem_fixed;

    mul_div_step #(.BitWidth(BitWidth)) u_step (
        .div_mode (is_div_q),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // Decode the request and form operand magnitudes and final sign-corrected results
    always_comb begin
        is_signed_op = (op == MULT) || (op == DIV);
        is_div_op    = (op == DIV) || (op == DIVU);
        is_long_op   = (op == MULT) || (op == MULTU) || is_div_op;
        b_zero       = (b == {BitWidth{1'b0}});
        a_neg        = is_signed_op && a[BitWidth-1];
        b_neg        = is_signed_op && b[BitWidth-1];
        a_mag        = a_neg ? -a : a;
        b_mag        = b_neg ? -b : b;
        prod_fixed   = neg_main_q ? -acc_q : acc_q;
        quot_fixed   = neg_main_q ? -acc_q[BitWidth-1:0] : acc_q[BitWidth-1:0];
        rem_fixed    = neg_rem_q ? -acc_q[2*BitWidth-1:BitWidth] : acc_q[2*BitWidth-1:BitWidth];
    end

    // State register and all datapath flops
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
        end
    end

    // Next-state: only long ops with a usable divisor enter CALC; cancel beats FIX completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && is_long_op && !(is_div_op && b_zero)) state_d = CALC;
            CALC: if (cancel) state_d = IDLE;
                  else if (cnt_q == LastStep) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; short ops (MTHI/MTLO, divide by zero) raise done one edge later via pend
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        pend_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                done_d = pend_q;
                if (start) begin
                    if (is_long_op && is_div_op && b_zero) begin
                        dbz_d  = 1'b1;
                        pend_d = 1'b1;
                    end else if (is_long_op) begin
                        dbz_d      = 1'b0;
                        cnt_d      = '0;
                        is_div_d   = is_div_op;
                        neg_main_d = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        acc_d      = {{BitWidth{1'b0}}, (is_div_op ? a_mag : b_mag)};
                        opnd_d     = is_div_op ? b_mag : a_mag;
                    end else if (op == MTHI) begin
                        hi_d   = a;
                        pend_d = 1'b1;
                    end else if (op == MTLO) begin
                        lo_d   = a;
                        pend_d = 1'b1;
                    end
                end
            end
            CALC: begin
                if (cancel) begin
                    cnt_d = '0;
                end else begin
                    acc_d = step_acc | {{(2*BitWidth-1){1'b0}}, step_q};
                    cnt_d = (cnt_q == LastStep) ? '0 : cnt_q + 1'b1;
                end
            end
            FIX: begin
                if (!cancel) begin
                    if (is_div_q) begin
                        hi_d = rem_fixed;
                        lo_d = quot_fixed;
                    end else begin
                        hi_d = prod_fixed[2*BitWidth-1:BitWidth];
                        lo_d = prod_fixed[BitWidth-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: busy is pure state, everything else straight from registers
    always_comb begin
        busy      = (state_q != IDLE);
        done      = done_q;
        hi        = hi_q;
        lo        = lo_q;
        divByZero = dbz_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit against a behavioural model
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset, start, cancel;
    MulDivCodeEnum op;
    logic [W-1:0]  a, b;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    mul_div_unit #(.BitWidth(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .divByZero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} of a long op, from plain integer arithmetic
    function automatic logic [63:0] ref_result(input MulDivCodeEnum o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        u  = 64'd0;
        case (o)
            MULT:  u = 64'(sx * sy);
            MULTU: u = {32'd0, x} * {32'd0, y};
            DIV: begin
                q = sx / sy;
                r = sx % sy;
                u = {r[31:0], q[31:0]};
            end
            DIVU:  u = {x % y, x / y};
            default: u = 64'd0;
        endcase
        return u;
    endfunction

    // Timing-level model: a long op takes W+1 edges, short ops signal done one edge later
    logic         m_busy = 0, m_done = 0, m_pend = 0, m_dbz = 0;
    int           m_left = 0;
    logic [W-1:0] m_hi = 0, m_lo = 0, m_rhi = 0, m_rlo = 0;
    logic         n_busy, n_done, n_pend, n_dbz;
    int           n_left;
    logic [W-1:0] n_hi, n_lo, n_rhi, n_rlo;
    logic [63:0]  n_res;

    always_comb begin
        n_busy = m_busy; n_done = 1'b0; n_pend = m_pend; n_dbz = m_dbz;
        n_left = m_left; n_hi = m_hi; n_lo = m_lo; n_rhi = m_rhi; n_rlo = m_rlo;
        n_res  = 64'd0;
        if (reset) begin
            n_busy = 0; n_pend = 0; n_dbz = 0; n_left = 0;
            n_hi = 0; n_lo = 0;
        end else if (m_busy) begin
            if (cancel) begin
                n_busy = 0;
            end else begin
                n_left = m_left - 1;
                if (m_left == 1) begin
                    n_hi = m_rhi; n_lo = m_rlo; n_busy = 0; n_done = 1;
                end
            end
        end else begin
            n_done = m_pend;
            n_pend = 0;
            if (start) begin
                if ((op == DIV || op == DIVU) && b == 0) begin
                    n_dbz = 1; n_pend = 1;
                end else if (op == MULT || op == MULTU || op == DIV || op == DIVU) begin
                    n_res  = ref_result(op, a, b);
                    n_rhi  = n_res[63:32];
                    n_rlo  = n_res[31:0];
                    n_dbz  = 0;
                    n_busy = 1;
                    n_left = W + 1;
                end else if (op == MTHI) begin
                    n_hi = a; n_pend = 1;
                end else if (op == MTLO) begin
                    n_lo = a; n_pend = 1;
                end
            end
        end
    end

    always @(posedge clock) begin
        m_busy <= n_busy; m_done <= n_done; m_pend <= n_pend; m_dbz <= n_dbz;
        m_left <= n_left; m_hi <= n_hi; m_lo <= n_lo; m_rhi <= n_rhi; m_rlo <= n_rlo;
    end

    // Compare process: every cycle once out of the initial reset
    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("divByZero", div_by_zero, m_dbz);
        end
    end

    task automatic issue(input MulDivCodeEnum o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clock);
        start = 1; op = o; a = x; b = y;
        @(negedge clock);
        start = 0; op = NONE; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom % 16);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        logic saw;
        reset = 1; start = 0; cancel = 0; op = NONE; a = 0; b = 0;

        // Literal pins on the reference arithmetic
        check("model_mult",  ref_result(MULT,  32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        check("model_multu", ref_result(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("model_divu",  ref_result(DIVU,  32'd100, 32'd7), {32'd2, 32'd14});
        check("model_div",   ref_result(DIV,   32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_minm1", ref_result(DIV,   32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        repeat (2) @(negedge clock);
        reset = 0;
        chk_en = 1;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dbz", div_by_zero, 0);

        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat);
        check("mult_latency", lat, 33);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        issue(DIVU, 32'd100, 32'd7);
        wait_done(lat);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check("minm1_lo", lo, 32'h8000_0000);
        check("minm1_hi", hi, 32'd0);
        check("minm1_dbz", div_by_zero, 0);

        issue(MULT, 32'd6, 32'd7);
        wait_done(lat);
        issue(DIV, 32'd5, 32'd0);
        wait_done(lat);
        check("dbz_latency", lat, 1);
        check("dbz_flag", div_by_zero, 1);
        check("dbz_lo_kept", lo, 32'd42);
        check("dbz_hi_kept", hi, 32'd0);
        issue(DIVU, 32'd9, 32'd2);
        check("dbz_cleared", div_by_zero, 0);
        wait_done(lat);
        check("divu9_lo", lo, 32'd4);

        // A second start while busy must be ignored
        issue(MULT, 32'd1234, 32'd5678);
        repeat (9) @(negedge clock);
        start = 1; op = DIVU; a = 32'd50; b = 32'd3;
        @(negedge clock);
        start = 0; op = NONE;
        wait_done(lat);
        check("intrude_lo", lo, 32'd7006652);
        check("intrude_hi", hi, 32'd0);

        // Cancel mid-CALC: no done, results kept
        issue(MULT, 32'd3, 32'd3);
        repeat (19) @(negedge clock);
        cancel = 1;
        @(negedge clock);
        cancel = 0;
        check("cancel_busy", busy, 0);
        saw = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) saw = 1;
        end
        check("cancel_no_done", saw, 0);
        check("cancel_lo_kept", lo, 32'd7006652);

        // Reset mid-DIV, then MTLO
        issue(DIV, 32'd1000, 32'd3);
        repeat (14) @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        check("midrst_busy", busy, 0);
        check("midrst_lo", lo, 0);
        check("midrst_hi", hi, 0);
        issue(MTLO, 32'h1234, 32'd0);
        check("mtlo_lo", lo, 32'h1234);
        check("mtlo_busy", busy, 0);
        wait_done(lat);
        check("mtlo_latency", lat, 1);
        issue(MTHI, 32'hCAFE_0001, 32'd0);
        wait_done(lat);
        check("mthi_hi", hi, 32'hCAFE_0001);

        // Random traffic including stray starts, cancels and resets
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            start  = ($urandom % 4) == 0;
            op     = MulDivCodeEnum'($urandom_range(0, 6));
            a      = rand_operand();
            b      = rand_operand();
            cancel = ($urandom % 60) == 0;
            reset  = ($urandom % 700) == 0;
        end
        @(negedge clock);
        start = 0; cancel = 0; reset = 0; op = NONE;
        repeat (40) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative, parametrised multiply/divide unit, the sequential companion to the combinational ALU. It executes MIPS MULT/MULTU/DIV/DIVU into a private HI/LO register pair and also services MTHI/MTLO. It sits beside the ALU in the execute stage. The pipeline stalls on `busy`, and MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `BitWidth`, default 32: operand and HI/LO width; must be even and ≥ 4.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  MulDivCodeEnum  NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a`  in  BitWidth  multiplicand / dividend / MTHI-MTLO source.
- `b`  in  BitWidth  multiplier / divisor.
- `cancel`  in  1  abort the in-flight operation.
- `busy`  out  BitWidth-independent 1  operation in progress; start is ignored while high.
- `done`  out  1  one-cycle pulse; `hi`/`lo`/`divByZero` are final.
- `hi`  out  BitWidth  HI register (product high half / remainder).
- `lo`  out  BitWidth  LO register (product low half / quotient).
- `divByZero`  out  1  last completed DIV/DIVU had b == 0.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start + MULT/MULTU/DIV/DIVU with a nonzero divisor:
  - latch operand magnitudes; for signed ops take two's-complement absolute values;
  - latch the sign-fix flags and clear `divByZero`;
  - go to CALC with counter = 0.
- CALC: one radix-2 step per cycle, for exactly BitWidth cycles, then go to FIX.
  - Multiply: shift-add into a 2·BitWidth accumulator.
  - Divide: restoring divide, one quotient bit per step.
- FIX (one cycle):
  - apply signs and write `hi`/`lo`; go to IDLE; pulse `done`.
  - MULT: negate the 2·BitWidth product if sign(a) ≠ sign(b).
  - DIV: negate the quotient if sign(a) ≠ sign(b); the remainder takes the sign of a. Division truncates toward zero.
  - DIV of MIN by −1: lo = MIN, hi = 0, no flag.
- Unsigned ops skip the negation; all arithmetic wraps modulo 2^BitWidth.
- DIV/DIVU with b == 0: no CALC phase. `hi`/`lo` are unchanged, `divByZero` = 1, and `done` pulses on the next cycle.
- MTHI/MTLO: writes `a` to hi/lo at the sampling edge; `busy` never rises; `done` pulses next cycle.
- `op` = NONE, or any start outside IDLE: ignored, no state change.
- `cancel` in CALC/FIX: return to IDLE at the next edge. `hi`/`lo`/`divByZero` are unchanged, and `done` does not pulse. `cancel` in IDLE has no effect.
- `cancel` has priority over FIX completion. `reset` has priority over everything.

## Timing
- Edge 0: start accepted; `busy` is 1 from this edge.
- Edges 1..BitWidth: the CALC steps.
- Edge BitWidth+1: hi/lo written, `busy` → 0, `done` → 1.
- Start-to-done latency is BitWidth+1 cycles, i.e. 33 for BitWidth = 32.
- `done` is high for exactly one cycle. A new start may be sampled in that same cycle (the unit is already IDLE).
- Div-by-zero and MTHI/MTLO: `done` at edge 1; `busy` stays 0.
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, divByZero 0, counter 0. Reset mid-CALC discards the operation.
- `a`, `b` and `op` need only be valid at the start edge; they are don't-care afterwards.

## Structure
- Shared package (Enum.sv): `MulDivCodeEnum` (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO) and `MulDivStateEnum` (IDLE, CALC, FIX).
- Function package: the counter width is `GetMinWidth(BitWidth)`, reused for the iteration counter.
- Sub-module `mul_div_step`: combinational single-iteration datapath. Inputs: mode, accumulator, operand. Outputs: next accumulator and next quotient bit.
- The FSM, counter, sign fix and HI/LO registers live in the top module.

## Test plan
- MULT a = −3, b = 5 (BitWidth 32) -> done at cycle 33; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; busy high cycles 0–32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- DIVU 100 / 7 -> lo = 14, hi = 2; DIV −7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 0x80000000 / −1 -> lo = 0x80000000, hi = 0.
- DIV 5 / 0 after a prior MULT -> done at cycle 1, divByZero = 1, hi/lo keep the MULT result; next valid start clears divByZero.
- Start MULT; assert start with a different op at cycle 10 -> ignored, original result unchanged. Assert cancel at cycle 20 -> busy 0 at cycle 21, no done, hi/lo unchanged.
- Reset at cycle 15 of a DIV -> all outputs zero next cycle. Then MTLO 0x1234 -> lo = 0x1234 next cycle, done pulse, busy stays 0.
